tx_burst_gen: RTL and testbench

//  Transmit burst generator, directly downstream of Ctrl. On a start request (enTx) it drives a

---
 rtl/tx_defs.sv | 25 ++
 rtl/tx_burst_gen.sv | 131 +++++++++++++
 tb/tb_tx_burst_gen.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_defs.sv
// Shared burst-generator definitions: state encodings and default timing.
// Ctrl and the receive stage import this to derive the burst duration.
package tx_defs;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // 40 kHz at 100 MHz, eight periods, 100 ns dead time per half period
    localparam int DEF_HALF_PERIOD = 1250;
    localparam int DEF_NUM_PULSES  = 8;
    localparam int DEF_DEAD_TIME   = 10;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } tx_state_t;

    // Cycles from the first burst cycle through the overTx cycle
    function automatic int burst_busy_cycles(input int half_period, input int num_pulses);
        return 2 * half_period * num_pulses + 1;
    endfunction

endpackage

// File: rtl/tx_burst_gen.sv
// Transmit burst generator: on a rising edge of enTx, drives NUM_PULSES
// periods of a complementary tx_p/tx_n pair with dead time at the start of
// each half period, then returns a one-cycle overTx pulse to Ctrl.
module tx_burst_gen
    import tx_defs::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int NUM_PULSES  = DEF_NUM_PULSES,
    parameter int DEAD_TIME   = DEF_DEAD_TIME
) (
    input  logic                              clk_100,
    input  logic                              rst_n,
    input  logic                              enTx,
    output logic                              tx_p,
    output logic                              tx_n,
    output logic                              busy,
    output logic [$clog2(NUM_PULSES+1)-1:0]   pulse_idx,
    output logic                              overTx
);

    localparam int PHASE_W = $clog2(2 * HALF_PERIOD);
    localparam int IDX_W   = $clog2(NUM_PULSES + 1);

    localparam logic [PHASE_W-1:0] PH_LAST    = PHASE_W'(2 * HALF_PERIOD - 1);
    localparam logic [PHASE_W-1:0] PH_P_START = PHASE_W'(DEAD_TIME);
    localparam logic [PHASE_W-1:0] PH_P_END   = PHASE_W'(HALF_PERIOD - 1);
    localparam logic [PHASE_W-1:0] PH_N_START = PHASE_W'(HALF_PERIOD + DEAD_TIME);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_PULSES - 1);

    // Parameter range checks at elaboration
    generate
        if (HALF_PERIOD < 2) begin : g_bad_half_period
            $error("tx_burst_gen: HALF_PERIOD must be >= 2");
        end
        if (NUM_PULSES < 1) begin : g_bad_num_pulses
            $error("tx_burst_gen: NUM_PULSES must be >= 1");
        end
        if (DEAD_TIME < 1 || DEAD_TIME >= HALF_PERIOD) begin : g_bad_dead_time
            $error("tx_burst_gen: DEAD_TIME must satisfy 1 <= DEAD_TIME < HALF_PERIOD");
        end
    endgenerate

    tx_state_t          state_reg,  state_next;
    logic [PHASE_W-1:0] phase_reg,  phase_next;
    logic [IDX_W-1:0]   pidx_reg,   pidx_next;
    logic               en_d_reg;
    logic               tx_p_reg,   tx_p_next;
    logic               tx_n_reg,   tx_n_next;
    logic               busy_reg,   busy_next;
    logic               over_reg,   over_next;
    logic               start;

    // Only a 0->1 transition of enTx requests a burst; the level is ignored
    assign start = enTx & ~en_d_reg;

    // Next state, phase/period counters and next output values
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        pidx_next  = pidx_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    phase_next = '0;
                    pidx_next  = '0;
                end
            end
            S_RUN: begin
                if (phase_reg == PH_LAST) begin
                    phase_next = '0;
                    if (pidx_reg == IDX_LAST) begin
                        state_next = S_DONE;
                        pidx_next  = '0;
                    end else begin
                        pidx_next = pidx_reg + IDX_W'(1);
                    end
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                phase_next = '0;
            end
            default: begin
                state_next = S_IDLE;
                phase_next = '0;
                pidx_next  = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registers line up
        // with the phase they describe, keeping enTx off any output path
        tx_p_next = (state_next == S_RUN) && (phase_next >= PH_P_START)
                    && (phase_next <= PH_P_END);
        tx_n_next = (state_next == S_RUN) && (phase_next >= PH_N_START);
        busy_next = (state_next != S_IDLE);
        over_next = (state_next == S_DONE);
    end

    // State, counters, edge detector and output registers
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            phase_reg <= '0;
            pidx_reg  <= '0;
            en_d_reg  <= 1'b0;
            tx_p_reg  <= 1'b0;
            tx_n_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            over_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            pidx_reg  <= pidx_next;
            en_d_reg  <= enTx;
            tx_p_reg  <= tx_p_next;
            tx_n_reg  <= tx_n_next;
            busy_reg  <= busy_next;
            over_reg  <= over_next;
        end
    end

    assign tx_p      = tx_p_reg;
    assign tx_n      = tx_n_reg;
    assign busy      = busy_reg;
    assign pulse_idx = pidx_reg;
    assign overTx    = over_reg;

endmodule

// File: tb/tb_tx_burst_gen.sv
// Bench for tx_burst_gen with HALF_PERIOD=5, NUM_PULSES=3, DEAD_TIME=1.
// Table rows describe enTx pulses per window; expected outputs are built
// from the burst timing rules into a queue and popped cycle by cycle.
module tb_tx_burst_gen;

    localparam int HP  = 5;
    localparam int NP  = 3;
    localparam int DT  = 1;
    localparam int RUN_LEN = 2 * HP * NP;
    localparam int WIN = 80;

    typedef struct packed {
        logic       tx_p;
        logic       tx_n;
        logic       busy;
        logic       over;
        logic [1:0] idx;
    } out_t;

    typedef struct {
        string name;
        int    rise1;
        int    fall1;
        int    rise2;
        int    fall2;
        int    n_over;
    } vec_t;

    logic       clk_100;
    logic       rst_n;
    logic       enTx;
    logic       tx_p;
    logic       tx_n;
    logic       busy;
    logic [1:0] pulse_idx;
    logic       overTx;

    int n_checks = 0;
    int n_pass   = 0;

    out_t exp_q[$];

    tx_burst_gen #(
        .HALF_PERIOD (HP),
        .NUM_PULSES  (NP),
        .DEAD_TIME   (DT)
    ) dut (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .enTx      (enTx),
        .tx_p      (tx_p),
        .tx_n      (tx_n),
        .busy      (busy),
        .pulse_idx (pulse_idx),
        .overTx    (overTx)
    );

    initial clk_100 = 1'b0;
    always #10 clk_100 = ~clk_100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outputs for cycle k of a burst (k = 0 .. RUN_LEN is the overTx cycle)
    function automatic out_t burst_out(input int k);
        out_t o;
        int ph;
        o = '0;
        o.busy = 1'b1;
        if (k == RUN_LEN) begin
            o.over = 1'b1;
        end else begin
            ph     = k % (2 * HP);
            o.idx  = 2'(k / (2 * HP));
            o.tx_p = (ph >= DT) && (ph <= HP - 1);
            o.tx_n = (ph >= HP + DT);
        end
        return o;
    endfunction

    function automatic out_t cur_out();
        out_t o;
        o.tx_p = tx_p;
        o.tx_n = tx_n;
        o.busy = busy;
        o.over = overTx;
        o.idx  = pulse_idx;
        return o;
    endfunction

    // Per-cycle invariants, sampled on the falling edge
    logic prev_over = 1'b0;
    always @(negedge clk_100) begin
        check("excl", 32'(tx_p && tx_n), 32'd0);
        check("over_twice", 32'(prev_over && overTx), 32'd0);
        check("idle_quiet", 32'(!busy && (tx_p || tx_n)), 32'd0);
        prev_over <= overTx;
    end

    initial begin
        vec_t vecs[5];
        logic en [WIN];
        out_t exp_arr [WIN];
        out_t got, want;
        int   next_ok, m, over_cnt, wait_cnt;
        bit   seen;

        vecs[0] = '{"single",     2, 4,  -1, -1, 1};
        vecs[1] = '{"held",       2, 45, -1, -1, 1};
        vecs[2] = '{"mid_run",    2, 3,  12, 14, 1};
        vecs[3] = '{"done_edge",  2, 4,  33, 36, 1};
        vecs[4] = '{"after_done", 2, 4,  34, 36, 2};

        rst_n = 1'b0;
        enTx  = 1'b0;
        @(posedge clk_100); #1;
        check("reset_state", 32'(cur_out()), 32'd0);
        @(posedge clk_100);
        @(posedge clk_100); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < WIN; i++) begin
                en[i] = ((i >= vecs[t].rise1) && (i < vecs[t].fall1)) ||
                        ((i >= vecs[t].rise2) && (i < vecs[t].fall2));
                exp_arr[i] = '0;
            end
            // enTx set in iteration i is sampled at edge i+1; a burst started
            // at edge m shows cycle k at iteration m+k; idle again from m+32
            next_ok = 0;
            for (int i = 0; i < WIN; i++) begin
                if (en[i] && !((i == 0) ? 1'b0 : en[i-1])) begin
                    m = i + 1;
                    if (m >= next_ok && m + RUN_LEN < WIN) begin
                        for (int k = 0; k <= RUN_LEN; k++) exp_arr[m+k] = burst_out(k);
                        next_ok = m + RUN_LEN + 2;
                    end
                end
            end
            for (int i = 0; i < WIN; i++) exp_q.push_back(exp_arr[i]);

            over_cnt = 0;
            for (int i = 0; i < WIN; i++) begin
                @(posedge clk_100); #1;
                got = cur_out();
                if (exp_q.size() == 0) begin
                    check({vecs[t].name, "_queue_empty"}, 32'd1, 32'd0);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want)
                        $display("FAIL %s cycle %0d: got p%0b n%0b busy%0b over%0b idx%0d, expected p%0b n%0b busy%0b over%0b idx%0d",
                                 vecs[t].name, i, got.tx_p, got.tx_n, got.busy, got.over, got.idx,
                                 want.tx_p, want.tx_n, want.busy, want.over, want.idx);
                    n_checks++;
                    if (got === want) n_pass++;
                end
                if (overTx) over_cnt++;
                enTx = en[i];
            end
            check({vecs[t].name, "_overTx_count"}, 32'(over_cnt), 32'(vecs[t].n_over));
        end

        // Reset in the tx_n half of the first period
        enTx = 1'b1;
        @(posedge clk_100); #1;
        check("rst_busy_rise", 32'(busy), 32'd1);
        enTx = 1'b0;
        for (int k = 0; k < 6; k++) @(posedge clk_100);
        #1;
        check("rst_pre_tx_n", 32'({tx_p, tx_n}), 32'b01);
        #5;
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", 32'(cur_out()), 32'd0);
        @(posedge clk_100);
        @(posedge clk_100); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk_100); #1;
            if (busy || overTx) seen = 1'b1;
        end
        check("rst_stays_idle", 32'(seen), 32'd0);

        // Fresh edge after reset runs a full burst
        enTx = 1'b1;
        @(posedge clk_100); #1;
        check("post_rst_start", 32'(cur_out()), 32'(burst_out(0)));
        enTx = 1'b0;
        wait_cnt = 0;
        seen = 1'b0;
        while (!seen && wait_cnt < 40) begin
            @(posedge clk_100); #1;
            wait_cnt++;
            if (overTx) seen = 1'b1;
        end
        check("post_rst_over_seen", 32'(seen), 32'd1);
        check("post_rst_over_time", 32'(wait_cnt), 32'(RUN_LEN));
        @(posedge clk_100); #1;
        check("post_rst_busy_fall", 32'(busy), 32'd0);

        repeat (2) @(posedge clk_100);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
